// File: rtl/shift_pkg.sv
// Shared types and constants for the RV32I shift execute stage.
// Also used by shift_exec_stage, whose optional SHIFT_EXEC_STATS_EN macro
// adds a completed-transfer counter.
package shift_pkg;

    localparam int SHIFT_XLEN = 32;
    // Width of the tag field carried in stage_t; RD_W must not exceed it.
    localparam int RD_FIELD_W = 16;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    typedef enum logic [1:0] {
        SH_SLL,
        SH_SRL,
        SH_SRA
    } shift_op_e;

    typedef struct packed {
        logic [SHIFT_XLEN-1:0] result;
        logic [RD_FIELD_W-1:0] rd;
        logic                  illegal;
    } stage_t;

    // funct7[5] only distinguishes SRA from SRL; it is ignored for SLL.
    function automatic shift_op_e decode_op(input logic [2:0] funct3, input logic funct7b5);
        if (funct3 == F3_SR) begin
            return funct7b5 ? SH_SRA : SH_SRL;
        end
        return SH_SLL;
    endfunction

    function automatic logic is_illegal(input logic [2:0] funct3);
        return !((funct3 == F3_SLL) || (funct3 == F3_SR));
    endfunction

endpackage

// File: rtl/barrel_shifter_right_32b.sv
// 32-bit logarithmic barrel shifter. Left shifts reuse the right-shift
// network by bit-reversing the operand before and the result after.
module barrel_shifter_right_32b (
    input  logic [31:0] inp,
    input  logic [4:0]  cntrl,
    input  logic        right,
    input  logic        arith,
    output logic [31:0] out
);

    logic [31:0] lvl [0:5];
    logic        fill;

    function automatic logic [31:0] bit_rev(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // Orient the operand and pick the fill bit (sign only for arithmetic right).
    always_comb begin
        lvl[0] = right ? inp : bit_rev(inp);
        fill   = arith & right & inp[31];
    end

    genvar k;
    generate
        for (k = 0; k < 5; k++) begin : g_lvl
            // Level k shifts right by 2**k when cntrl[k] is set.
            always_comb begin
                lvl[k+1] = cntrl[k] ? {{(1 << k){fill}}, lvl[k][31:(1 << k)]} : lvl[k];
            end
        end
    endgenerate

    // Undo the bit reversal for left shifts.
    always_comb begin
        out = right ? lvl[5] : bit_rev(lvl[5]);
    end

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage RV32I shift execute stage: operand register -> barrel shifter ->
// result register, valid/ready on both sides, with flush.
// Optional macro SHIFT_EXEC_STATS_EN adds stat_count_o (completed transfers).
module shift_exec_stage
    import shift_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      in_funct3_i,
    input  logic            in_funct7b5_i,
    input  logic            in_use_imm_i,
    input  logic [XLEN-1:0] in_rs1_i,
    input  logic [XLEN-1:0] in_rs2_i,
    input  logic [4:0]      in_imm_shamt_i,
    input  logic [RD_W-1:0] in_rd_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_result_o,
    output logic [RD_W-1:0] out_rd_o,
    output logic            out_illegal_o
`ifdef SHIFT_EXEC_STATS_EN
    ,
    output logic [31:0]     stat_count_o
`endif
);

    generate
        if (XLEN != SHIFT_XLEN) begin : g_bad_xlen
            $error("shift_exec_stage: only XLEN=32 is supported");
        end
        if (RD_W < 1 || RD_W > RD_FIELD_W) begin : g_bad_rd_w
            $error("shift_exec_stage: RD_W out of range");
        end
    endgenerate

    logic            vld_p1;
    logic [31:0]     inp_p1;
    logic [4:0]      cntrl_p1;
    shift_op_e       op_p1;
    logic            illegal_p1;
    logic [RD_W-1:0] rd_p1;

    logic            vld_p2;
    stage_t          out_p2;

    logic            accept;
    logic            load_p2;
    logic [31:0]     shifted;
    logic            unused_bits;

    assign in_ready_o = !vld_p1 || !vld_p2 || out_ready_i;
    // Flush discards an op offered in the same cycle, even if ready is high.
    assign accept     = in_valid_i && in_ready_o && !flush_i;
    assign load_p2    = vld_p1 && (!vld_p2 || out_ready_i);

    assign unused_bits = ^{in_rs2_i[XLEN-1:5], out_p2.rd};

    // ---- stage 1: operand register ----

    // Stage-1 occupancy: flush wins, then accept, then hand-off to stage 2.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld_p1 <= 1'b0;
        end else if (flush_i) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (load_p2) begin
            vld_p1 <= 1'b0;
        end
    end

    // Capture decoded operands on every accepted op.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            inp_p1     <= in_rs1_i[31:0];
            cntrl_p1   <= in_use_imm_i ? in_imm_shamt_i : in_rs2_i[4:0];
            op_p1      <= decode_op(in_funct3_i, in_funct7b5_i);
            illegal_p1 <= is_illegal(in_funct3_i);
            rd_p1      <= in_rd_i;
        end
    end

    barrel_shifter_right_32b u_shifter (
        .inp   (inp_p1),
        .cntrl (cntrl_p1),
        .right (op_p1 != SH_SLL),
        .arith (op_p1 == SH_SRA),
        .out   (shifted)
    );

    // ---- stage 2: result register ----

    // Output valid and payload; payload only moves when stage 1 hands off.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld_p2 <= 1'b0;
            out_p2 <= '0;
        end else begin
            if (flush_i) begin
                vld_p2 <= 1'b0;
            end else if (load_p2) begin
                vld_p2 <= 1'b1;
            end else if (out_ready_i) begin
                vld_p2 <= 1'b0;
            end
            if (load_p2 && !flush_i) begin
                out_p2.result  <= illegal_p1 ? 32'd0 : shifted;
                out_p2.rd      <= RD_FIELD_W'(rd_p1);
                out_p2.illegal <= illegal_p1;
            end
        end
    end

    assign out_valid_o   = vld_p2;
    assign out_result_o  = out_p2.result;
    assign out_rd_o      = out_p2.rd[RD_W-1:0];
    assign out_illegal_o = out_p2.illegal;

`ifdef SHIFT_EXEC_STATS_EN
    logic [31:0] stat_cnt;

    // Count every completed output handshake; flush does not clear it.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stat_cnt <= 32'd0;
        end else if (vld_p2 && out_ready_i) begin
            stat_cnt <= stat_cnt + 32'd1;
        end
    end

    assign stat_count_o = stat_cnt;
`endif

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed self-checking bench for shift_exec_stage.
module tb_shift_exec_stage;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        use_imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  imm_shamt;
    logic [4:0]  rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_illegal;
`ifdef SHIFT_EXEC_STATS_EN
    logic [31:0] stat_count;
`endif

    int vectors;
    int miscompares;

    shift_exec_stage #(.XLEN(32), .RD_W(5)) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .flush_i        (flush),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_funct3_i    (funct3),
        .in_funct7b5_i  (funct7b5),
        .in_use_imm_i   (use_imm),
        .in_rs1_i       (rs1),
        .in_rs2_i       (rs2),
        .in_imm_shamt_i (imm_shamt),
        .in_rd_i        (rd),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_result_o   (out_result),
        .out_rd_o       (out_rd),
        .out_illegal_o  (out_illegal)
`ifdef SHIFT_EXEC_STATS_EN
        ,
        .stat_count_o   (stat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic v, input logic [2:0] f3, input logic b5, input logic imm,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                      input logic [4:0] tag);
        in_valid  = v;
        funct3    = f3;
        funct7b5  = b5;
        use_imm   = imm;
        rs1       = a;
        rs2       = b;
        imm_shamt = sh;
        rd        = tag;
        #1;
    endtask

    task automatic idle();
        op(1'b0, 3'b001, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    endtask

    task automatic chk_out(input string tag, input logic [31:0] res, input logic [4:0] tg,
                           input logic ill);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".result"}, out_result, res);
        chk({tag, ".rd"}, {27'd0, out_rd}, {27'd0, tg});
        chk({tag, ".illegal"}, {31'd0, out_illegal}, {31'd0, ill});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b1;
        idle();

        // Reset state
        #12;
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.out_result", out_result, 32'd0);
        chk("rst.out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst.out_illegal", {31'd0, out_illegal}, 32'd0);
        rstn = 1'b1;
        tick();
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);

        // SLL by register: 1 << 31, two-cycle latency
        op(1'b1, 3'b001, 1'b0, 1'b0, 32'h0000_0001, 32'd31, 5'd0, 5'd7);
        tick();
        idle();
        chk("sll31.lat1", {31'd0, out_valid}, 32'd0);
        tick();
        chk_out("sll31", 32'h8000_0000, 5'd7, 1'b0);

        // SRA imm then SRL imm on consecutive cycles
        op(1'b1, 3'b101, 1'b1, 1'b1, 32'h8000_00F0, 32'h0, 5'd4, 5'd1);
        tick();
        op(1'b1, 3'b101, 1'b0, 1'b1, 32'h8000_00F0, 32'h0, 5'd4, 5'd2);
        tick();
        idle();
        chk_out("sra4", 32'hF800_000F, 5'd1, 1'b0);
        tick();
        chk_out("srl4", 32'h0800_000F, 5'd2, 1'b0);

        // Upper rs2 bits ignored (funct7b5 set on SLL is also ignored); shamt 0 SRA
        op(1'b1, 3'b001, 1'b1, 1'b0, 32'h0000_0001, 32'hFFFF_FFE3, 5'd0, 5'd3);
        tick();
        op(1'b1, 3'b101, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0, 5'd0, 5'd4);
        tick();
        idle();
        chk_out("sll_mask", 32'h0000_0008, 5'd3, 1'b0);
        tick();
        chk_out("sra0", 32'hDEAD_BEEF, 5'd4, 1'b0);
        tick();
        chk("drained", {31'd0, out_valid}, 32'd0);

        // Backpressure: four ops against a stalled sink
        out_ready = 1'b0;
        op(1'b1, 3'b001, 1'b0, 1'b1, 32'h1, 32'h0, 5'd1, 5'd10);
        chk("bp.rdy_a", {31'd0, in_ready}, 32'd1);
        tick();
        op(1'b1, 3'b001, 1'b0, 1'b1, 32'h1, 32'h0, 5'd2, 5'd11);
        chk("bp.rdy_b", {31'd0, in_ready}, 32'd1);
        tick();
        op(1'b1, 3'b001, 1'b0, 1'b1, 32'h1, 32'h0, 5'd3, 5'd12);
        chk("bp.rdy_c_full", {31'd0, in_ready}, 32'd0);
        chk_out("bp.a_head", 32'h2, 5'd10, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp.full_hold", {31'd0, in_ready}, 32'd0);
            chk_out("bp.a_stable", 32'h2, 5'd10, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.rdy_release", {31'd0, in_ready}, 32'd1);
        tick();
        chk_out("bp.b", 32'h4, 5'd11, 1'b0);
        op(1'b1, 3'b001, 1'b0, 1'b1, 32'h1, 32'h0, 5'd4, 5'd13);
        tick();
        idle();
        chk_out("bp.c", 32'h8, 5'd12, 1'b0);
        tick();
        chk_out("bp.d", 32'h10, 5'd13, 1'b0);
        tick();
        chk("bp.empty", {31'd0, out_valid}, 32'd0);

        // Illegal funct3
        op(1'b1, 3'b000, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 5'd3, 5'd5);
        tick();
        idle();
        tick();
        chk_out("illegal", 32'h0, 5'd5, 1'b1);
        tick();

        // Flush with two ops in flight and a third offered in the flush cycle
        out_ready = 1'b0;
        op(1'b1, 3'b001, 1'b0, 1'b1, 32'h1, 32'h0, 5'd5, 5'd20);
        tick();
        op(1'b1, 3'b001, 1'b0, 1'b1, 32'h1, 32'h0, 5'd6, 5'd21);
        tick();
        op(1'b1, 3'b001, 1'b0, 1'b1, 32'h1, 32'h0, 5'd7, 5'd22);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        chk("flush.valid", {31'd0, out_valid}, 32'd0);
        chk("flush.in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("flush.no_ghost1", {31'd0, out_valid}, 32'd0);
        tick();
        chk("flush.no_ghost2", {31'd0, out_valid}, 32'd0);
        op(1'b1, 3'b001, 1'b0, 1'b1, 32'h3, 32'h0, 5'd8, 5'd23);
        tick();
        idle();
        chk("flush.next_lat1", {31'd0, out_valid}, 32'd0);
        tick();
        chk_out("flush.next", 32'h0000_0300, 5'd23, 1'b0);
        tick();

`ifdef SHIFT_EXEC_STATS_EN
        chk("stats.count", stat_count, 32'd11);
`endif

        // Asynchronous reset mid-stream
        op(1'b1, 3'b001, 1'b0, 1'b1, 32'h1, 32'h0, 5'd9, 5'd24);
        tick();
        tick();
        chk_out("arst.pre", 32'h0000_0200, 5'd24, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst.valid_now", {31'd0, out_valid}, 32'd0);
        chk("arst.result_now", out_result, 32'd0);
`ifdef SHIFT_EXEC_STATS_EN
        chk("arst.stats", stat_count, 32'd0);
`endif
        idle();
        tick();
        rstn = 1'b1;
        tick();
        chk("arst.post1", {31'd0, out_valid}, 32'd0);
        tick();
        chk("arst.post2", {31'd0, out_valid}, 32'd0);
        chk("arst.in_ready", {31'd0, in_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Two-stage pipelined execute stage wrapping the 32-bit logarithmic barrel shifter (barrel_shifter_right_32b).
- Accepts decoded RV32I shift micro-ops (SLL/SRL/SRA and immediate forms) from the decode/issue stage over a valid/ready handshake.
- Drives the barrel shifter from an operand register and registers the result with its destination tag toward writeback.
- Supports full backpressure and a pipeline flush.

Parameters:
- XLEN, 32, data width; only 32 is supported and is checked at elaboration.
- RD_W, 5, destination register tag width.

Ports:
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous kill of all in-flight ops
- in_valid_i  in  1  upstream op valid
- in_ready_o  out  1  stage can accept op
- in_funct3_i  in  3  001=SLL, 101=SRL/SRA; other codes illegal
- in_funct7b5_i  in  1  instr[30]: 1 selects SRA when funct3=101
- in_use_imm_i  in  1  shamt from in_imm_shamt_i instead of in_rs2_i[4:0]
- in_rs1_i  in  XLEN  value to shift
- in_rs2_i  in  XLEN  register shift operand; only [4:0] used
- in_imm_shamt_i  in  5  immediate shift amount
- in_rd_i  in  RD_W  destination tag
- out_valid_o  out  1  result valid
- out_ready_i  in  1  writeback accepts
- out_result_o  out  XLEN  shifted value
- out_rd_o  out  RD_W  destination tag
- out_illegal_o  out  1  op had an illegal funct3; out_result_o=0

Behaviour:
- Reset (rstn_i low, asynchronous):
  - stage-1 valid=0, out_valid_o=0, out_result_o=0, out_rd_o=0, out_illegal_o=0.
  - in_ready_o=1 once rstn_i is high.
- Stage 1, operand register, captured on in_valid_i && in_ready_o:
  - inp=rs1.
  - cntrl = in_use_imm_i ? in_imm_shamt_i : in_rs2_i[4:0].
  - right = (funct3==101).
  - arith = right && funct7b5. funct7b5 is ignored for SLL.
  - illegal = funct3 not in {001,101}.
  - rd.
- The barrel shifter is driven combinationally from stage-1 registers only. There is no combinational path from in_* to out_*.
- Stage 2, output register: loads shifter output (or 0 if illegal), rd and illegal when stage-1 is valid and stage 2 is empty or draining (out_ready_i).
- Latency: exactly 2 cycles from accept to out_valid_o with no backpressure. Throughput 1 op/cycle.
- Handshake:
  - in_ready_o = !s1_valid || !out_valid_o || out_ready_i. This may depend combinationally on out_ready_i.
  - out_valid_o and the out_* payload stay stable while out_valid_o && !out_ready_i.
  - in_* must be stable while in_valid_i && !in_ready_o; this is the upstream obligation.
- Full: both stages valid and out_ready_i=0 gives in_ready_o=0. No op is lost or duplicated.
- Simultaneous accept and drain: the stage-1 op moves to stage 2 and the new op enters stage 1 in the same cycle.
- Arithmetic:
  - shamt is masked to 5 bits; rs2[31:5] is ignored.
  - shamt=0 gives result=rs1 for all three ops.
  - SRA fills with rs1[31].
- flush_i:
  - Clears stage-1 valid and out_valid_o next edge.
  - An op presented with in_valid_i in the flush cycle is discarded even if in_ready_o=1.
  - flush_i has priority over accept and drain.
  - in_ready_o=1 the cycle after.
- Reset mid-operation: all in-flight ops are dropped immediately and asynchronously. No output pulse after deassertion.

Optional Feature:
- Macro: SHIFT_EXEC_STATS_EN.
- Defined:
  - Adds output stat_count_o (32 bits).
  - Counts completed output transfers (out_valid_o && out_ready_i), illegal ops included.
  - Wraps at 2^32; reset to 0; not affected by flush_i.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package shift_pkg:
  - funct3 constants F3_SLL=3'b001, F3_SR=3'b101.
  - Shift-op enum {SH_SLL, SH_SRL, SH_SRA}.
  - Packed stage struct {result, rd, illegal}.
- One sub-module: barrel_shifter_right_32b, instantiated unmodified.
- Decode and the two pipeline registers stay in shift_exec_stage.

Test Plan:
- Reset then SLL, rs1=0x0000_0001, rs2=31, out_ready=1 -> 2 cycles later result 0x8000_0000, rd echoed, illegal=0.
- SRA imm, rs1=0x8000_00F0, shamt=4; then SRL same operands -> 0xF800_000F then 0x0800_000F on consecutive cycles.
- rs2=0xFFFF_FFE3 (shamt=3), SLL rs1=0x1 -> 0x8 (upper rs2 bits ignored); shamt=0 SRA rs1=0xDEAD_BEEF -> 0xDEAD_BEEF.
- Stream 4 ops while holding out_ready_i=0 for 5 cycles -> in_ready_o drops after 2 accepted; out payload stable; all 4 emerge in order once released.
- funct3=3'b000 -> out_illegal_o=1, result 0. flush_i with 2 ops in flight -> no output valid; next op appears 2 cycles after accept.
- Reset asserted asynchronously mid-stream -> out_valid_o=0 immediately. With SHIFT_EXEC_STATS_EN defined, stat_count_o equals the number of completed transfers.
